dbg_guv: RTL and testbench
==========================

Name: dbg_guv

Overview:
- Debug governor wrapped around a single AXI-Stream link (in -> out).
- Runtime commands arrive on a daisy-chained command bus and can do four things:
  - pause the stream;
  - drop a counted or unlimited number of flits;
  - copy (log) a counted or unlimited number of flits to a log stream, with TKEEP concatenated into the log data;
  - inject one arbitrary flit.
- Many instances are chained cmd_out -> cmd_in, each with a unique ADDR.

Parameters:
- DATA_WIDTH, 64: width of in/out TDATA and of the command word; must be >= 36+ADDR_WIDTH.
- DEST_WIDTH, 16: TDEST width; must be <= 32.
- ID_WIDTH, 16: TID width; must be <= 32.
- CNT_SIZE, 16: width of drop/log counters; must be <= 32.
- ADDR_WIDTH, 12: command address field width.
- ADDR, 0: this instance's address.
- RESET_TYPE, 0: kept for interface compatibility only; rst is always asynchronous active-high.
- STICKY_MODE, 1: 1 = shadow registers keep their values after a latch; 0 = shadow registers clear to 0 after a latch.
- PIPE_STAGE, 0: 1 = cmd_out is registered (one-cycle delay).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cmd_in_TDATA  in  DATA_WIDTH  command word
- cmd_in_TVALID  in  1  command valid; this block never backpressures it
- cmd_out_TDATA  out  DATA_WIDTH  forwarded command
- cmd_out_TVALID  out  1  forwarded command valid
- in_TDATA/TVALID/TREADY(out)/TKEEP/TDEST/TID/TLAST  in  DATA_WIDTH/1/1/DATA_WIDTH/8/DEST_WIDTH/ID_WIDTH/1  upstream stream
- out_TDATA/TVALID/TREADY(in)/TKEEP/TDEST/TID/TLAST  out  same widths  downstream stream
- log_catted_TDATA  out  DATA_WIDTH+DATA_WIDTH/8  {in_TKEEP, in_TDATA}
- log_catted_TVALID  out  1  log flit valid
- log_catted_TREADY  in  1  log backpressure
- log_catted_TLAST  out  1  copy of in_TLAST

Behaviour:
- Command fields: value = cmd[31:0]; reg = cmd[35:32]; addr = cmd[35+ADDR_WIDTH:36]. A command matches when cmd_in_TVALID && addr==ADDR.
- A matching command writes a shadow register on the clock edge and is consumed, not forwarded.
- Non-matching commands are forwarded unchanged:
  - PIPE_STAGE=0: combinational pass-through; cmd_out_TVALID = cmd_in_TVALID & ~match.
  - PIPE_STAGE=1: registered, one-cycle latency; cmd_out_TVALID resets to 0.
- Shadow registers, selected by reg:
  - 0 keep_pausing = value[0]
  - 1 keep_logging = value[0]
  - 2 log_cnt = value[CNT_SIZE-1:0]
  - 3 keep_dropping = value[0]
  - 4 drop_cnt = value[CNT_SIZE-1:0]
  - 5 inject_TDATA: shift register, inject_TDATA <= {inject_TDATA[DATA_WIDTH-33:0], value}
  - 6 inject_TKEEP = value
  - 7 inject_TDEST = value
  - 8 inject_TID = value
  - 9 inject_TLAST = value[0]
  - 10 inject_TVALID = value[0]
  - 15 latch
  - Other reg codes are ignored.
- Latch: copies all shadow registers into active registers in one cycle.
  - If STICKY_MODE=0, the shadows clear to 0 on that same edge.
- Async reset: all shadow and active registers and counters go to 0. Outputs after reset: in_TREADY=out_TREADY, out_TVALID=in_TVALID, log_catted_TVALID=0, cmd_out_TVALID=0 (registered case).
- Derived terms:
  - dropping = keep_dropping | (drop_cnt!=0)
  - logging = keep_logging | (log_cnt!=0)
  - paused = keep_pausing
- Inject has highest priority, and applies even while paused. While active inject_TVALID=1:
  - out carries the inject registers; out_TVALID=1; in_TREADY=0; log_catted_TVALID=0.
  - On the out handshake, active inject_TVALID clears to 0.
- Otherwise, if paused: in_TREADY=0, out_TVALID=0, log_catted_TVALID=0.
- Otherwise, pass-through. out_* data and sidechannels mirror in_*, and:
  - out_TVALID = in_TVALID & ~dropping & (~logging | log_catted_TREADY)
  - log_catted_TVALID = in_TVALID & logging & (dropping | out_TREADY)
  - in_TREADY = (dropping | out_TREADY) & (~logging | log_catted_TREADY)
  - Logging is lossless: out and log advance together.
- Counters, per in-stream handshake:
  - drop_cnt decrements when nonzero and the flit was dropped.
  - log_cnt decrements when nonzero and the flit was logged.
  - A flit may be both logged and dropped; it then appears only on log.
  - Counters saturate at 0.
- Latch coinciding with a handshake: the latch wins; the counter loads the shadow value.
- A latch while an inject is pending overwrites it.

Test Plan:
- Two instances chained, ADDR 0 and 1, both in_TVALID=1, all TREADY=1.
  - Send 0x0000001000000001 (addr1, reg0, value 1), then 0x0000001F00000000 (addr1 latch).
  - Required: instance 1 in_TREADY=0 and out_TVALID=0 from the cycle after the latch; instance 0 unaffected; cmd12 forwards both commands; instance 1 cmd_out_TVALID stays 0.
- Addr0 drop_cnt=3 (0x0000000400000003) then latch.
  - Required: exactly the next 3 in flits are accepted with out_TVALID=0; the 4th passes.
- Addr0 log_cnt=2 then latch.
  - Required: 2 log_catted flits with TDATA={TKEEP,TDATA}, matching out; with log_catted_TREADY=0, in_TREADY=0 until ready returns.
- While paused, inject: reg5 value 0xDEADBEEF, reg5 value 0x12345678, reg10 value 1, then latch.
  - Required: a single out flit with TDATA=0xDEADBEEF12345678; in_TREADY stays 0; out_TVALID drops the next cycle.
- STICKY_MODE=0: set keep_pausing=1, latch, then latch again.
  - Required: paused after the first latch, unpaused after the second.
- Assert rst mid-drop.
  - Required: outputs return immediately to pass-through; counters read 0.

Source files
------------

// File: rtl/dbg_guv.sv
// Debug governor on one AXI-Stream link: pause, drop, log and inject flits.
// Commands travel on a daisy-chained bus and are consumed when the address matches.
module dbg_guv #(
   parameter int unsigned DATA_WIDTH  = 64,
   parameter int unsigned DEST_WIDTH  = 16,
   parameter int unsigned ID_WIDTH    = 16,
   parameter int unsigned CNT_SIZE    = 16,
   parameter int unsigned ADDR_WIDTH  = 12,
   parameter int unsigned ADDR        = 0,
   parameter int unsigned RESET_TYPE  = 0,
   parameter int unsigned STICKY_MODE = 1,
   parameter int unsigned PIPE_STAGE  = 0
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [DATA_WIDTH-1:0]              cmd_in_TDATA,
   input  logic                               cmd_in_TVALID,
   output logic [DATA_WIDTH-1:0]              cmd_out_TDATA,
   output logic                               cmd_out_TVALID,
   input  logic [DATA_WIDTH-1:0]              in_TDATA,
   input  logic                               in_TVALID,
   output logic                               in_TREADY,
   input  logic [DATA_WIDTH/8-1:0]            in_TKEEP,
   input  logic [DEST_WIDTH-1:0]              in_TDEST,
   input  logic [ID_WIDTH-1:0]                in_TID,
   input  logic                               in_TLAST,
   output logic [DATA_WIDTH-1:0]              out_TDATA,
   output logic                               out_TVALID,
   input  logic                               out_TREADY,
   output logic [DATA_WIDTH/8-1:0]            out_TKEEP,
   output logic [DEST_WIDTH-1:0]              out_TDEST,
   output logic [ID_WIDTH-1:0]                out_TID,
   output logic                               out_TLAST,
   output logic [DATA_WIDTH+DATA_WIDTH/8-1:0] log_catted_TDATA,
   output logic                               log_catted_TVALID,
   input  logic                               log_catted_TREADY,
   output logic                               log_catted_TLAST
);
   localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;

   // Reset style is fixed; the parameter survives only for drop-in compatibility.
   logic unused_reset_type;
   assign unused_reset_type = 1'(RESET_TYPE);

   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [3:0]            cmd_reg;
   logic [31:0]           cmd_val;
   logic                  match;
   logic                  latch;

   assign cmd_addr = cmd_in_TDATA[35+ADDR_WIDTH:36];
   assign cmd_reg  = cmd_in_TDATA[35:32];
   assign cmd_val  = cmd_in_TDATA[31:0];
   assign match    = cmd_in_TVALID && (cmd_addr == ADDR_WIDTH'(ADDR));
   assign latch    = match && (cmd_reg == 4'd15);

   logic                  sh_pausing, sh_logging, sh_dropping;
   logic [CNT_SIZE-1:0]   sh_log_cnt, sh_drop_cnt;
   logic [DATA_WIDTH-1:0] sh_inj_data;
   logic [KEEP_WIDTH-1:0] sh_inj_keep;
   logic [DEST_WIDTH-1:0] sh_inj_dest;
   logic [ID_WIDTH-1:0]   sh_inj_id;
   logic                  sh_inj_last, sh_inj_valid;

   logic                  keep_pausing, keep_logging, keep_dropping;
   logic [CNT_SIZE-1:0]   log_cnt, drop_cnt;
   logic [DATA_WIDTH-1:0] inj_data;
   logic [KEEP_WIDTH-1:0] inj_keep;
   logic [DEST_WIDTH-1:0] inj_dest;
   logic [ID_WIDTH-1:0]   inj_id;
   logic                  inj_last, inj_valid;

   logic dropping, logging, in_hs;
   assign dropping = keep_dropping | (drop_cnt != '0);
   assign logging  = keep_logging | (log_cnt != '0);
   assign in_hs    = in_TVALID & in_TREADY;

   // Shadow registers, written by matching commands
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_pausing   <= 1'b0;
         sh_logging   <= 1'b0;
         sh_dropping  <= 1'b0;
         sh_log_cnt   <= '0;
         sh_drop_cnt  <= '0;
         sh_inj_data  <= '0;
         sh_inj_keep  <= '0;
         sh_inj_dest  <= '0;
         sh_inj_id    <= '0;
         sh_inj_last  <= 1'b0;
         sh_inj_valid <= 1'b0;
      end else if (latch && (STICKY_MODE == 0)) begin
         sh_pausing   <= 1'b0;
         sh_logging   <= 1'b0;
         sh_dropping  <= 1'b0;
         sh_log_cnt   <= '0;
         sh_drop_cnt  <= '0;
         sh_inj_data  <= '0;
         sh_inj_keep  <= '0;
         sh_inj_dest  <= '0;
         sh_inj_id    <= '0;
         sh_inj_last  <= 1'b0;
         sh_inj_valid <= 1'b0;
      end else if (match) begin
         case (cmd_reg)
            4'd0:    sh_pausing   <= cmd_val[0];
            4'd1:    sh_logging   <= cmd_val[0];
            4'd2:    sh_log_cnt   <= CNT_SIZE'(cmd_val);
            4'd3:    sh_dropping  <= cmd_val[0];
            4'd4:    sh_drop_cnt  <= CNT_SIZE'(cmd_val);
            4'd5:    sh_inj_data  <= {sh_inj_data[DATA_WIDTH-33:0], cmd_val};
            4'd6:    sh_inj_keep  <= KEEP_WIDTH'(cmd_val);
            4'd7:    sh_inj_dest  <= DEST_WIDTH'(cmd_val);
            4'd8:    sh_inj_id    <= ID_WIDTH'(cmd_val);
            4'd9:    sh_inj_last  <= cmd_val[0];
            4'd10:   sh_inj_valid <= cmd_val[0];
            default: ;
         endcase
      end
   end

   // Active registers: a latch overrides counter updates and pending injects
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         keep_pausing  <= 1'b0;
         keep_logging  <= 1'b0;
         keep_dropping <= 1'b0;
         log_cnt       <= '0;
         drop_cnt      <= '0;
         inj_data      <= '0;
         inj_keep      <= '0;
         inj_dest      <= '0;
         inj_id        <= '0;
         inj_last      <= 1'b0;
         inj_valid     <= 1'b0;
      end else if (latch) begin
         keep_pausing  <= sh_pausing;
         keep_logging  <= sh_logging;
         keep_dropping <= sh_dropping;
         log_cnt       <= sh_log_cnt;
         drop_cnt      <= sh_drop_cnt;
         inj_data      <= sh_inj_data;
         inj_keep      <= sh_inj_keep;
         inj_dest      <= sh_inj_dest;
         inj_id        <= sh_inj_id;
         inj_last      <= sh_inj_last;
         inj_valid     <= sh_inj_valid;
      end else begin
         if (in_hs && dropping && (drop_cnt != '0)) drop_cnt <= drop_cnt - CNT_SIZE'(1);
         if (in_hs && logging && (log_cnt != '0))   log_cnt  <= log_cnt - CNT_SIZE'(1);
         if (inj_valid && out_TREADY)               inj_valid <= 1'b0;
      end
   end

   assign log_catted_TDATA = {in_TKEEP, in_TDATA};
   assign log_catted_TLAST = in_TLAST;

   // Stream steering: inject beats pause, pause beats pass-through
   always_comb begin
      out_TDATA         = in_TDATA;
      out_TKEEP         = in_TKEEP;
      out_TDEST         = in_TDEST;
      out_TID           = in_TID;
      out_TLAST         = in_TLAST;
      out_TVALID        = in_TVALID & ~dropping & (~logging | log_catted_TREADY);
      log_catted_TVALID = in_TVALID & logging & (dropping | out_TREADY);
      in_TREADY         = (dropping | out_TREADY) & (~logging | log_catted_TREADY);
      if (inj_valid) begin
         out_TDATA         = inj_data;
         out_TKEEP         = inj_keep;
         out_TDEST         = inj_dest;
         out_TID           = inj_id;
         out_TLAST         = inj_last;
         out_TVALID        = 1'b1;
         log_catted_TVALID = 1'b0;
         in_TREADY         = 1'b0;
      end else if (keep_pausing) begin
         out_TVALID        = 1'b0;
         log_catted_TVALID = 1'b0;
         in_TREADY         = 1'b0;
      end
   end

   generate
      if (PIPE_STAGE != 0) begin : g_cmd_pipe
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               cmd_out_TDATA  <= '0;
               cmd_out_TVALID <= 1'b0;
            end else begin
               cmd_out_TDATA  <= cmd_in_TDATA;
               cmd_out_TVALID <= cmd_in_TVALID & ~match;
            end
         end
      end else begin : g_cmd_comb
         assign cmd_out_TDATA  = cmd_in_TDATA;
         assign cmd_out_TVALID = cmd_in_TVALID & ~match;
      end
   endgenerate

endmodule

// File: tb/tb_dbg_guv.sv
// Randomized scoreboard bench for dbg_guv: three chained instances (ADDR 0,1,2),
// instance 0 checked against a flit-level model, instances 1/2 with directed checks.
module tb_dbg_guv;
   typedef struct packed {
      logic [63:0] d;
      logic [7:0]  k;
      logic [15:0] dest;
      logic [15:0] id;
      logic        last;
   } flit_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [63:0] cmd_a_d, cmd_b_d, cmd_c_d, cmd_d_d;
   logic        cmd_a_v, cmd_b_v, cmd_c_v, cmd_d_v;

   logic [63:0] s0_d;  logic s0_v, s0_r; logic [7:0] s0_k; logic [15:0] s0_dest, s0_id; logic s0_l;
   logic [63:0] o0_d;  logic o0_v, o0_r; logic [7:0] o0_k; logic [15:0] o0_dest, o0_id; logic o0_l;
   logic [71:0] l0_d;  logic l0_v, l0_r, l0_l;

   logic [63:0] sx_d;  logic sx_v; logic [7:0] sx_k; logic [15:0] sx_dest, sx_id; logic sx_l;
   logic        sx_or, sx_lr;
   logic s1_r, s2_r;
   logic [63:0] o1_d, o2_d; logic o1_v, o2_v; logic [7:0] o1_k, o2_k;
   logic [15:0] o1_dest, o2_dest, o1_id, o2_id; logic o1_l, o2_l;
   logic [71:0] l1_d, l2_d; logic l1_v, l2_v, l1_l, l2_l;

   dbg_guv #(.ADDR(0)) u0 (
      .clk(clk), .rst(rst),
      .cmd_in_TDATA(cmd_a_d), .cmd_in_TVALID(cmd_a_v),
      .cmd_out_TDATA(cmd_b_d), .cmd_out_TVALID(cmd_b_v),
      .in_TDATA(s0_d), .in_TVALID(s0_v), .in_TREADY(s0_r), .in_TKEEP(s0_k),
      .in_TDEST(s0_dest), .in_TID(s0_id), .in_TLAST(s0_l),
      .out_TDATA(o0_d), .out_TVALID(o0_v), .out_TREADY(o0_r), .out_TKEEP(o0_k),
      .out_TDEST(o0_dest), .out_TID(o0_id), .out_TLAST(o0_l),
      .log_catted_TDATA(l0_d), .log_catted_TVALID(l0_v),
      .log_catted_TREADY(l0_r), .log_catted_TLAST(l0_l));

   dbg_guv #(.ADDR(1)) u1 (
      .clk(clk), .rst(rst),
      .cmd_in_TDATA(cmd_b_d), .cmd_in_TVALID(cmd_b_v),
      .cmd_out_TDATA(cmd_c_d), .cmd_out_TVALID(cmd_c_v),
      .in_TDATA(sx_d), .in_TVALID(sx_v), .in_TREADY(s1_r), .in_TKEEP(sx_k),
      .in_TDEST(sx_dest), .in_TID(sx_id), .in_TLAST(sx_l),
      .out_TDATA(o1_d), .out_TVALID(o1_v), .out_TREADY(sx_or), .out_TKEEP(o1_k),
      .out_TDEST(o1_dest), .out_TID(o1_id), .out_TLAST(o1_l),
      .log_catted_TDATA(l1_d), .log_catted_TVALID(l1_v),
      .log_catted_TREADY(sx_lr), .log_catted_TLAST(l1_l));

   dbg_guv #(.ADDR(2), .STICKY_MODE(0), .PIPE_STAGE(1)) u2 (
      .clk(clk), .rst(rst),
      .cmd_in_TDATA(cmd_c_d), .cmd_in_TVALID(cmd_c_v),
      .cmd_out_TDATA(cmd_d_d), .cmd_out_TVALID(cmd_d_v),
      .in_TDATA(sx_d), .in_TVALID(sx_v), .in_TREADY(s2_r), .in_TKEEP(sx_k),
      .in_TDEST(sx_dest), .in_TID(sx_id), .in_TLAST(sx_l),
      .out_TDATA(o2_d), .out_TVALID(o2_v), .out_TREADY(sx_or), .out_TKEEP(o2_k),
      .out_TDEST(o2_dest), .out_TID(o2_id), .out_TLAST(o2_l),
      .log_catted_TDATA(l2_d), .log_catted_TVALID(l2_v),
      .log_catted_TREADY(sx_lr), .log_catted_TLAST(l2_l));

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chkw(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Flit-level reference model of instance 0
   flit_t       out_q[$];
   logic        out_inj_q[$];
   logic [72:0] log_q[$];
   logic  sh_pause, sh_klog, sh_kdrop, sh_injv;
   int    sh_lcnt, sh_dcnt;
   flit_t sh_inj;
   logic  m_pause, m_klog, m_kdrop, m_injpend;
   int    m_lcnt, m_dcnt;

   task automatic model_reset();
      sh_pause = 0; sh_klog = 0; sh_kdrop = 0; sh_injv = 0; sh_lcnt = 0; sh_dcnt = 0;
      sh_inj = '0;
      m_pause = 0; m_klog = 0; m_kdrop = 0; m_injpend = 0; m_lcnt = 0; m_dcnt = 0;
      out_q.delete(); out_inj_q.delete(); log_q.delete();
   endtask

   task automatic model_cmd(input logic [11:0] addr, input logic [3:0] r, input logic [31:0] val);
      if (addr == 12'd0) begin
         case (r)
            4'd0:  sh_pause = val[0];
            4'd1:  sh_klog = val[0];
            4'd2:  sh_lcnt = int'(val[15:0]);
            4'd3:  sh_kdrop = val[0];
            4'd4:  sh_dcnt = int'(val[15:0]);
            4'd5:  sh_inj.d = (sh_inj.d << 32) | 64'(val);
            4'd6:  sh_inj.k = val[7:0];
            4'd7:  sh_inj.dest = val[15:0];
            4'd8:  sh_inj.id = val[15:0];
            4'd9:  sh_inj.last = val[0];
            4'd10: sh_injv = val[0];
            4'd15: begin
               m_pause = sh_pause; m_klog = sh_klog; m_kdrop = sh_kdrop;
               m_lcnt = sh_lcnt; m_dcnt = sh_dcnt;
               if (sh_injv) begin
                  out_q.push_back(sh_inj);
                  out_inj_q.push_back(1'b1);
                  m_injpend = 1'b1;
               end
            end
            default: ;
         endcase
      end
   endtask

   task automatic model_accept(input flit_t f);
      logic drop, lg;
      chk1("accept_allowed", !(m_pause || m_injpend), 1'b1);
      drop = m_kdrop || (m_dcnt > 0);
      lg   = m_klog || (m_lcnt > 0);
      if (lg) log_q.push_back({f.last, f.k, f.d});
      if (!drop) begin
         out_q.push_back(f);
         out_inj_q.push_back(1'b0);
      end
      if (drop && m_dcnt > 0) m_dcnt--;
      if (lg && m_lcnt > 0) m_lcnt--;
   endtask

   // Monitor: pops expectations when instance 0 completes an out or log handshake
   logic  mon_en = 1'b0;
   flit_t mon_e;
   logic  mon_inj;
   logic [72:0] mon_l;
   always begin
      @(negedge clk);
      #1;
      if (mon_en) begin
         if (o0_v && o0_r) begin
            if (out_q.size() == 0) chk1("out_unexpected", o0_v, 1'b0);
            else begin
               mon_e = out_q.pop_front();
               mon_inj = out_inj_q.pop_front();
               chkw("out_flit", 128'({o0_d, o0_k, o0_dest, o0_id, o0_l}), 128'(mon_e));
               if (mon_inj) m_injpend = 1'b0;
            end
         end
         if (l0_v && l0_r) begin
            if (log_q.size() == 0) chk1("log_unexpected", l0_v, 1'b0);
            else begin
               mon_l = log_q.pop_front();
               chkw("log_flit", 128'({l0_l, l0_d}), 128'(mon_l));
            end
         end
      end
   end

   logic rdy_rand = 1'b0;
   always begin
      @(posedge clk);
      #1;
      if (rdy_rand) begin
         o0_r = ($urandom_range(0, 3) != 0);
         l0_r = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic send_cmd(input logic [11:0] addr, input logic [3:0] r, input logic [31:0] val);
      logic [63:0] c;
      c = {16'h0, addr, r, val};
      cmd_a_d = c;
      cmd_a_v = 1'b1;
      model_cmd(addr, r, val);
      @(negedge clk);
      chk1("cmd_fwd0_valid", cmd_b_v, addr != 12'd0);
      if (addr != 12'd0) chkw("cmd_fwd0_data", 128'(cmd_b_d), 128'(c));
      chk1("cmd_fwd1_valid", cmd_c_v, addr > 12'd1);
      @(posedge clk); #1;
      cmd_a_v = 1'b0;
      @(negedge clk);
      chk1("cmd_pipe_valid", cmd_d_v, addr > 12'd2);
      if (addr > 12'd2) chkw("cmd_pipe_data", 128'(cmd_d_d), 128'(c));
      @(posedge clk); #1;
   endtask

   function automatic flit_t rand_flit();
      flit_t f;
      f.d = {$urandom, $urandom};
      f.k = 8'($urandom);
      f.dest = 16'($urandom);
      f.id = 16'($urandom);
      f.last = 1'($urandom);
      return f;
   endfunction

   task automatic drive(input flit_t f);
      s0_d = f.d; s0_k = f.k; s0_dest = f.dest; s0_id = f.id; s0_l = f.last;
      s0_v = 1'b1;
   endtask

   task automatic wait_accept(input flit_t f);
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (s0_v && s0_r) begin
            model_accept(f);
            break;
         end
         if (n == 199) chk1("accept_timeout", s0_r, 1'b1);
      end
      @(posedge clk); #1;
      s0_v = 1'b0;
   endtask

   task automatic run_flits(input int n);
      flit_t f;
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         f = rand_flit();
         drive(f);
         wait_accept(f);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 400; i++) begin
         if (out_q.size() == 0 && log_q.size() == 0) break;
         @(posedge clk); #1;
      end
      chkw("drain_out", 128'(out_q.size()), 128'd0);
      chkw("drain_log", 128'(log_q.size()), 128'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   flit_t hf;
   initial begin
      model_reset();
      rst = 1'b1;
      cmd_a_d = '0; cmd_a_v = 1'b0;
      s0_d = '0; s0_v = 1'b0; s0_k = '0; s0_dest = '0; s0_id = '0; s0_l = 1'b0;
      o0_r = 1'b1; l0_r = 1'b1;
      sx_d = 64'hA5A5_0000_1111_2222; sx_v = 1'b1; sx_k = 8'hFF; sx_dest = 16'h3;
      sx_id = 16'h4; sx_l = 1'b1; sx_or = 1'b1; sx_lr = 1'b1;
      repeat (2) @(negedge clk);
      chk1("rst_in_ready", s0_r, 1'b1);
      chk1("rst_out_valid", o0_v, 1'b0);
      chk1("rst_log_valid", l0_v, 1'b0);
      chk1("rst_cmd_pipe_valid", cmd_d_v, 1'b0);
      chk1("rst_u1_out_valid", o1_v, 1'b1);
      rst = 1'b0;
      @(posedge clk); #1;
      mon_en = 1'b1;
      rdy_rand = 1'b1;

      run_flits(20);
      drain();

      // Counted drop
      send_cmd(12'd0, 4'd4, 32'd3);
      send_cmd(12'd0, 4'd15, 32'd0);
      run_flits(10);
      drain();

      // Counted log, then a random drop count mixed with log
      send_cmd(12'd0, 4'd4, 32'd0);
      send_cmd(12'd0, 4'd2, 32'd2);
      send_cmd(12'd0, 4'd15, 32'd0);
      run_flits(8);
      drain();
      send_cmd(12'd0, 4'd4, 32'($urandom_range(1, 5)));
      send_cmd(12'd0, 4'd2, 32'($urandom_range(1, 5)));
      send_cmd(12'd0, 4'd15, 32'd0);
      run_flits(12);
      drain();

      // Log backpressure stalls input losslessly
      send_cmd(12'd0, 4'd4, 32'd0);
      send_cmd(12'd0, 4'd2, 32'd2);
      send_cmd(12'd0, 4'd15, 32'd0);
      rdy_rand = 1'b0;
      @(posedge clk); #1;
      o0_r = 1'b1; l0_r = 1'b0;
      hf = rand_flit();
      drive(hf);
      repeat (3) begin
         @(negedge clk);
         chk1("logbp_in_ready", s0_r, 1'b0);
         chk1("logbp_out_valid", o0_v, 1'b0);
         @(posedge clk); #1;
      end
      l0_r = 1'b1;
      wait_accept(hf);
      rdy_rand = 1'b1;
      run_flits(4);
      drain();

      // Unlimited log + drop: flits appear only on log
      send_cmd(12'd0, 4'd2, 32'd0);
      send_cmd(12'd0, 4'd1, 32'd1);
      send_cmd(12'd0, 4'd3, 32'd1);
      send_cmd(12'd0, 4'd15, 32'd0);
      run_flits(8);
      drain();
      send_cmd(12'd0, 4'd1, 32'd0);
      send_cmd(12'd0, 4'd3, 32'd0);
      send_cmd(12'd0, 4'd15, 32'd0);

      // Pause, then inject while paused
      send_cmd(12'd0, 4'd0, 32'd1);
      send_cmd(12'd0, 4'd15, 32'd0);
      hf = rand_flit();
      drive(hf);
      repeat (4) begin
         @(negedge clk);
         chk1("pause_in_ready", s0_r, 1'b0);
         chk1("pause_out_valid", o0_v, 1'b0);
         @(posedge clk); #1;
      end
      send_cmd(12'd0, 4'd5, 32'hDEADBEEF);
      send_cmd(12'd0, 4'd5, 32'h12345678);
      send_cmd(12'd0, 4'd6, 32'h0000_00FF);
      send_cmd(12'd0, 4'd7, 32'h0000_00AB);
      send_cmd(12'd0, 4'd8, 32'h0000_00CD);
      send_cmd(12'd0, 4'd9, 32'd1);
      send_cmd(12'd0, 4'd10, 32'd1);
      send_cmd(12'd0, 4'd15, 32'd0);
      chkw("inject_queued", 128'(out_q.size()), 128'd1);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         chk1("inject_in_ready", s0_r, 1'b0);
         #2;
         if (out_q.size() == 0) break;
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk1("inject_once", o0_v, 1'b0);
      @(posedge clk); #1;
      send_cmd(12'd0, 4'd10, 32'd0);
      send_cmd(12'd0, 4'd0, 32'd0);
      send_cmd(12'd0, 4'd15, 32'd0);
      wait_accept(hf);
      run_flits(6);
      drain();

      // Chained instance 1 pause; instance 0 keeps streaming afterwards
      @(negedge clk);
      chk1("u1_ready_before", s1_r, 1'b1);
      @(posedge clk); #1;
      send_cmd(12'd1, 4'd0, 32'd1);
      send_cmd(12'd1, 4'd15, 32'd0);
      @(negedge clk);
      chk1("u1_paused_ready", s1_r, 1'b0);
      chk1("u1_paused_valid", o1_v, 1'b0);
      chk1("u0_not_paused", s0_r | ~o0_r, 1'b1);
      @(posedge clk); #1;
      send_cmd(12'd1, 4'd0, 32'd0);
      send_cmd(12'd1, 4'd15, 32'd0);
      @(negedge clk);
      chk1("u1_resumed_ready", s1_r, 1'b1);
      @(posedge clk); #1;
      run_flits(5);
      drain();

      // Non-sticky instance 2: second latch clears the pause
      send_cmd(12'd2, 4'd0, 32'd1);
      send_cmd(12'd2, 4'd15, 32'd0);
      @(negedge clk);
      chk1("u2_paused_ready", s2_r, 1'b0);
      chk1("u2_paused_valid", o2_v, 1'b0);
      @(posedge clk); #1;
      send_cmd(12'd2, 4'd15, 32'd0);
      @(negedge clk);
      chk1("u2_unpaused_ready", s2_r, 1'b1);
      chk1("u2_unpaused_valid", o2_v, 1'b1);
      @(posedge clk); #1;
      send_cmd(12'd5, 4'd3, 32'h0BAD_F00D);

      // Reset in the middle of unlimited dropping
      send_cmd(12'd0, 4'd3, 32'd1);
      send_cmd(12'd0, 4'd15, 32'd0);
      run_flits(4);
      drain();
      rdy_rand = 1'b0;
      @(posedge clk); #1;
      o0_r = 1'b1; l0_r = 1'b1;
      hf = rand_flit();
      drive(hf);
      @(negedge clk);
      chk1("drop_out_valid", o0_v, 1'b0);
      #2;
      mon_en = 1'b0;
      rst = 1'b1;
      #1;
      chk1("rst_mid_out_valid", o0_v, 1'b1);
      chk1("rst_mid_in_ready", s0_r, 1'b1);
      chk1("rst_mid_log_valid", l0_v, 1'b0);
      s0_v = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(posedge clk); #1;
      mon_en = 1'b1;
      rdy_rand = 1'b1;
      run_flits(10);
      drain();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
